// File: rtl/ufm_arbiter_if.sv
// ufm_arbiter_if: request/acknowledge bus between the two UFM read masters
// and ufm_arbiter.
//
//   req0/addr0 -> ack0   port 0 (CPU fetch) request, word address, ack pulse
//   req1/addr1 -> ack1   port 1 (boot/config loader) request, address, ack pulse
//   rdata                last word read, valid on the ack pulse and held after
//   busy                 arbiter is running a UFM sequence
//
// Modports: slave = arbiter side, master = requester side.
interface ufm_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport slave (
        input  req0, addr0, req1, addr1,
        output ack0, ack1, rdata, busy
    );

    modport master (
        output req0, addr0, req1, addr1,
        input  ack0, ack1, rdata, busy
    );
endinterface

// File: rtl/ufm_arbiter.sv
// ufm_arbiter: two-port read controller for the on-chip UFM serial interface.
// Arbitrates between port 0 (CPU fetch) and port 1 (boot/config loader),
// shifts the word address into the UFM MSB first, latches the data register,
// shifts the word out MSB first and returns it with a one-cycle ack.
//
// Ports:
//   clock        UFM oscillator clock, all logic on posedge
//   reset        synchronous, active-high
//   bus          ufm_arbiter_if.slave (req0/addr0/ack0, req1/addr1/ack1,
//                rdata, busy)
//   ufm_ardin    serial address bit to the UFM
//   ufm_arshft   address register shift enable, tied high
//   ufm_drshft   0 = load data register, 1 = shift data register
//   ufm_drdout   serial data bit from the UFM
//
// Build option UFM_CACHE_EN: adds a one-entry (address, word) cache. A grant
// that hits the cache skips the UFM access; no UFM pin toggles.
//
// state | meaning
// IDLE  | waiting for a request; grants one and captures its address
// ADDR  | ADDR_W cycles driving the address onto ufm_ardin, MSB first
// LATCH | one cycle with ufm_drshft=0 so the UFM loads its data register
// SHIFT | DATA_W cycles shifting ufm_drdout into data_sr
// DONE  | publish data_sr to rdata and pulse the granted ack
module ufm_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic            clock,
    input  logic            reset,
    ufm_arbiter_if.slave    bus,
    output logic            ufm_ardin,
    output logic            ufm_arshft,
    output logic            ufm_drshft,
    input  logic            ufm_drdout
);

    localparam int CNT_W  = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
    localparam int AIDX_W = $clog2(ADDR_W);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              grant_q,   grant_d;
    logic              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
    logic [DATA_W-1:0] data_sr_q, data_sr_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              ack0_q,    ack0_d;
    logic              ack1_q,    ack1_d;
    logic              busy_q,    busy_d;
    logic              ardin_q,   ardin_d;
    logic              drshft_q,  drshft_d;

`ifdef UFM_CACHE_EN
    logic              cache_vld_q,  cache_vld_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_W-1:0] cache_data_q, cache_data_d;
    logic              hit_q,        hit_d;
`endif

    logic              grant_sel;
    logic [ADDR_W-1:0] grant_addr;
    logic [CNT_W-1:0]  cnt_m1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        addr_sr_d  = addr_sr_q;
        data_sr_d  = data_sr_q;
        rdata_d    = rdata_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        ardin_d    = 1'b0;
        drshft_d   = 1'b0;
        cnt_m1     = cnt_q - 1'b1;
        // On a tie the port that did not win last time gets the grant.
        grant_sel  = (bus.req0 && bus.req1) ? ~rr_last_q : bus.req1;
        grant_addr = grant_sel ? bus.addr1 : bus.addr0;
`ifdef UFM_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        cache_data_d = cache_data_q;
        hit_d        = hit_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_d   = grant_sel;
                    rr_last_d = grant_sel;
                    addr_sr_d = grant_addr;
`ifdef UFM_CACHE_EN
                    // A hit passes through LATCH with the UFM pins quiet so
                    // the ack lands two edges after the grant.
                    if (cache_vld_q && (cache_addr_q == grant_addr)) begin
                        hit_d     = 1'b1;
                        data_sr_d = cache_data_q;
                        state_d   = LATCH;
                    end else begin
                        hit_d     = 1'b0;
                        state_d   = ADDR;
                        cnt_d     = ADDR_LAST;
                        ardin_d   = grant_addr[ADDR_W-1];
                    end
`else
                    state_d = ADDR;
                    cnt_d   = ADDR_LAST;
                    ardin_d = grant_addr[ADDR_W-1];
`endif
                end
            end

            ADDR: begin
                // cnt_q is the index of the bit currently on ufm_ardin.
                if (cnt_q == '0) begin
                    state_d = LATCH;
                end else begin
                    cnt_d   = cnt_m1;
                    ardin_d = addr_sr_q[cnt_m1[AIDX_W-1:0]];
                end
            end

            LATCH: begin
`ifdef UFM_CACHE_EN
                if (hit_q) begin
                    state_d = DONE;
                end else begin
                    state_d  = SHIFT;
                    cnt_d    = DATA_LAST;
                    drshft_d = 1'b1;
                end
`else
                state_d  = SHIFT;
                cnt_d    = DATA_LAST;
                drshft_d = 1'b1;
`endif
            end

            SHIFT: begin
                data_sr_d = {data_sr_q[DATA_W-2:0], ufm_drdout};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d    = cnt_m1;
                    drshft_d = 1'b1;
                end
            end

            DONE: begin
                rdata_d = data_sr_q;
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                state_d = IDLE;
`ifdef UFM_CACHE_EN
                cache_vld_d  = 1'b1;
                cache_addr_d = addr_sr_q;
                cache_data_d = data_sr_q;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            addr_sr_q <= '0;
            data_sr_q <= '0;
            rdata_q   <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            ardin_q   <= 1'b0;
            drshft_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            addr_sr_q <= addr_sr_d;
            data_sr_q <= data_sr_d;
            rdata_q   <= rdata_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            ardin_q   <= ardin_d;
            drshft_q  <= drshft_d;
        end
    end

`ifdef UFM_CACHE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            cache_data_q <= '0;
            hit_q        <= 1'b0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            cache_data_q <= cache_data_d;
            hit_q        <= hit_d;
        end
    end
`endif

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = busy_q;
    assign ufm_ardin  = ardin_q;
    assign ufm_arshft = 1'b1;
    assign ufm_drshft = drshft_q;

endmodule

// File: tb/tb_ufm_arbiter.sv
// tb_ufm_arbiter: scoreboard bench for ufm_arbiter with a behavioural UFM.
// Expected (port, word, ack cycle) entries are queued when a request is
// driven and popped when an ack is seen.
module tb_ufm_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
`ifdef UFM_CACHE_EN
    localparam int HIT_LAT = 3;
    localparam int HIT_DRS = 0;
`else
    localparam int HIT_LAT = 28;
    localparam int HIT_DRS = 16;
`endif

    logic clock;
    logic reset;
    logic ufm_ardin, ufm_arshft, ufm_drshft, ufm_drdout;

    ufm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ufm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .ufm_ardin  (ufm_ardin),
        .ufm_arshft (ufm_arshft),
        .ufm_drshft (ufm_drshft),
        .ufm_drdout (ufm_drdout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural UFM: address register shifts on every edge, data register
    // loads while drshft=0 and shifts MSB first while drshft=1.
    function automatic logic [DATA_W-1:0] ufm_word(input logic [ADDR_W-1:0] a);
        case (a)
            9'h0A5:  return 16'hBEEF;
            9'h001:  return 16'h1234;
            9'h1FF:  return 16'hA55A;
            default: return {7'h15, a};
        endcase
    endfunction

    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    always @(posedge clock) begin
        if (ufm_arshft) m_addr <= {m_addr[ADDR_W-2:0], ufm_ardin};
        if (!ufm_drshft) m_data <= ufm_word(m_addr);
        else             m_data <= {m_data[DATA_W-2:0], 1'b0};
    end
    assign ufm_drdout = m_data[DATA_W-1];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always @(negedge clock) begin
        if (!reset && (bus.ack0 || bus.ack1)) begin
            chk("ack_onehot", 32'(bus.ack0) + 32'(bus.ack1), 1);
            if (sb.size() == 0) begin
                chk("ack_unexpected", {bus.ack1, bus.ack0}, 0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", bus.ack1, e.port);
                chk("rdata", bus.rdata, e.data);
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic port, input logic [DATA_W-1:0] data, input int at);
        exp_t x;
        x.port = port;
        x.data = data;
        x.cyc  = at;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Master model: hold each req for the given number of acks, then drop it.
    task automatic serve(input int rem0_i, input int rem1_i, input int max_cyc,
                         output int busy_lo, output int drs_hi);
        int rem0;
        int rem1;
        int n;
        rem0 = rem0_i;
        rem1 = rem1_i;
        n = 0;
        busy_lo = 0;
        drs_hi = 0;
        while ((bus.req0 || bus.req1) && n < max_cyc) begin
            tick();
            n++;
            if (!bus.busy) busy_lo++;
            if (ufm_drshft) drs_hi++;
            if (bus.ack0 && rem0 > 0) begin
                rem0--;
                if (rem0 == 0) bus.req0 = 1'b0;
            end
            if (bus.ack1 && rem1 > 0) begin
                rem1--;
                if (rem1 == 0) bus.req1 = 1'b0;
            end
        end
        chk("serve_done", {bus.req1, bus.req0}, 0);
        tick();
        chk("idle_after", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int bl;
        int dh;
        logic [ADDR_W-1:0] seq;
        int lo_bad;
        int hi_cnt;

        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ardin", ufm_ardin, 0);
        chk("rst_drshft", ufm_drshft, 0);
        chk("arshft", ufm_arshft, 1);

        // Single read of 0x0A5 with a pin-level trace.
        c = cyc;
        bus.addr0 = 9'h0A5;
        bus.req0 = 1'b1;
        push(1'b0, 16'hBEEF, c + 28);
        tick();
        chk("busy_rise", bus.busy, 1);
        seq = '0;
        lo_bad = 0;
        hi_cnt = 0;
        for (int k = 0; k < ADDR_W; k++) begin
            seq = {seq[ADDR_W-2:0], ufm_ardin};
            if (ufm_drshft) lo_bad++;
            tick();
        end
        chk("ardin_seq", seq, 9'h0A5);
        chk("addr_drshft", lo_bad, 0);
        chk("latch_drshft", ufm_drshft, 0);
        chk("latch_ardin", ufm_ardin, 0);
        tick();
        for (int j = 0; j < DATA_W; j++) begin
            if (ufm_drshft) hi_cnt++;
            tick();
        end
        chk("shift_cycles", hi_cnt, 16);
        chk("done_drshft", ufm_drshft, 0);
        chk("early_ack0", bus.ack0, 0);
        tick();
        chk("t1_ack0", bus.ack0, 1);
        chk("t1_ack1", bus.ack1, 0);
        bus.req0 = 1'b0;
        tick();
        chk("t1_idle", bus.busy, 0);

        // Simultaneous requests straight after reset: port 0 first.
        do_reset();
        c = cyc;
        bus.addr0 = 9'h001;
        bus.addr1 = 9'h1FF;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        push(1'b0, 16'h1234, c + 28);
        push(1'b1, 16'hA55A, c + 56);
        serve(1, 1, 100, bl, dh);
        chk("tie_busy_lo", bl, 2);

        // Both held for four words: strict alternation, one idle cycle each.
        do_reset();
        c = cyc;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        push(1'b0, 16'h1234, c + 28);
        push(1'b1, 16'hA55A, c + 56);
        push(1'b0, 16'h1234, c + 84);
        push(1'b1, 16'hA55A, c + 112);
        serve(2, 2, 200, bl, dh);
        chk("alt_busy_lo", bl, 4);
        chk("alt_drshft", dh, 64);

        // Reset in the middle of a read discards it.
        do_reset();
        bus.addr0 = 9'h0A5;
        bus.req0 = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick();
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_drshft", ufm_drshft, 0);
        chk("mid_rst_acks", {bus.ack1, bus.ack0}, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("mid_rst_quiet", bus.busy, 0);
        c = cyc;
        bus.req0 = 1'b1;
        push(1'b0, 16'hBEEF, c + 28);
        serve(1, 0, 60, bl, dh);
        chk("fresh_drshft", dh, 16);

        // Same address again: cache hit when enabled, full sequence otherwise.
        c = cyc;
        bus.req0 = 1'b1;
        push(1'b0, 16'hBEEF, c + HIT_LAT);
        serve(1, 0, 60, bl, dh);
        chk("repeat_drshft", dh, HIT_DRS);

        // req1 dropped mid-read and its address changed; req0 waits.
        do_reset();
        c = cyc;
        bus.addr1 = 9'h1FF;
        bus.req1 = 1'b1;
        push(1'b1, 16'hA55A, c + 28);
        tick();
        tick();
        tick();
        bus.addr1 = 9'h001;
        tick();
        tick();
        bus.req1 = 1'b0;
        bus.addr0 = 9'h0A5;
        bus.req0 = 1'b1;
        push(1'b0, 16'hBEEF, c + 56);
        serve(1, 0, 100, bl, dh);

        tick();
        tick();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
